// File: rtl/kim_tty_terminal.sv
// KIM-1 TTY serial terminal bridge: byte-wide host interface to the KIM's
// bit-serial TTY lines. Independent transmitter (host -> TTYI) and receiver
// (TTYO -> host), both 8N1/8N2 with no parity and a fixed bit period.
module kim_tty_terminal #(
    parameter int unsigned CLKS_PER_BIT = 3125,
    parameter int unsigned STOP_BITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TTYI,
    input  logic       TTYO,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
    // Sized so one counter covers the longest interval, the stop period.
    localparam int unsigned CntW       = $clog2(StopCycles + 1);

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(StopCycles - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            ttyi_q, ttyi_d;

    // TX next-state: line level is registered, so each decision lands one cycle later.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        ttyi_d     = ttyi_q;
        tx_ready   = (tx_state_q == TxIdle);

        unique case (tx_state_q)
            TxIdle: begin
                ttyi_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    ttyi_d     = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    ttyi_d     = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        ttyi_d     = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        // Shift toward bit 0 so the next bit is always at index 1.
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        ttyi_d     = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                ttyi_d = 1'b1;
                if (tx_cnt_q == StopLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                ttyi_d     = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ttyi_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ttyi_q     <= ttyi_d;
        end
    end

    assign TTYI = ttyi_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    logic            ttyo_s1_q, ttyo_s2_q, ttyo_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_frame_err_q, rx_frame_err_d;
    logic            rx_overrun_q, rx_overrun_d;
    logic            rx_deliver;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ttyo_s1_q   <= 1'b1;
            ttyo_s2_q   <= 1'b1;
            ttyo_prev_q <= 1'b1;
        end else begin
            ttyo_s1_q   <= TTYO;
            ttyo_s2_q   <= ttyo_s1_q;
            ttyo_prev_q <= ttyo_s2_q;
        end
    end

    // RX next-state, sampling, and host-side holding register.
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        rx_frame_err_d = 1'b0;
        rx_overrun_d   = 1'b0;
        rx_deliver     = 1'b0;

        unique case (rx_state_q)
            RxIdle: begin
                if (ttyo_prev_q && !ttyo_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A glitch shorter than half a bit is a false start.
                    rx_state_d = ttyo_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {ttyo_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    if (ttyo_s2_q) begin
                        rx_deliver = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxWaitHigh: begin
                // Holding here keeps a long break from raising repeated errors.
                if (ttyo_s2_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase

        if (rx_deliver) begin
            if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q     <= RxIdle;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_kim_tty_terminal.sv
// Directed bench for kim_tty_terminal at CLKS_PER_BIT=16, STOP_BITS=2.
module tb_kim_tty_terminal;

    localparam int Cpb = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       TTYI;
    logic       ttyo_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       ttyo_w;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overrun;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    assign ttyo_w = loop_en ? TTYI : ttyo_drv;

    kim_tty_terminal #(
        .CLKS_PER_BIT(Cpb),
        .STOP_BITS   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .TTYI        (TTYI),
        .TTYO        (ttyo_w),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle status outputs.
    always @(posedge clk) begin
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame on TTYO; rx_ready is raised at cycle rdy_lo and dropped at rdy_hi.
    task automatic send_frame(input logic [7:0] d, input int nstop, input logic stop_val,
                              input int rdy_lo, input int rdy_hi);
        int b;
        @(posedge clk);
        #1;
        ttyo_drv = 1'b0;
        for (int c = 1; c < (9 + nstop) * Cpb; c++) begin
            @(posedge clk);
            #1;
            b = c / Cpb;
            if (b == 0) ttyo_drv = 1'b0;
            else if (b <= 8) ttyo_drv = d[b-1];
            else ttyo_drv = stop_val;
            if (c == rdy_lo) rx_ready = 1'b1;
            if (c == rdy_hi) rx_ready = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    int fe_base;
    int ov_base;
    int waited;
    logic [7:0] byte_v;
    logic exp_line;

    initial begin
        // Reset state
        tick(3);
        check("rst_ttyi", 32'(TTYI), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        reset = 1'b0;
        tick(2);

        // TX 0x55 waveform; bench changes tx_data/tx_valid mid-frame
        byte_v = 8'h55;
        tx_data = byte_v;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int c = 1; c <= 177; c++) begin
            if (c > 1) tick(1);
            if (c <= 16) exp_line = 1'b0;
            else if (c <= 144) exp_line = byte_v[(c - 17) / 16];
            else exp_line = 1'b1;
            check($sformatf("tx_ttyi_c%0d", c), 32'(TTYI), 32'(exp_line));
            if (c == 176) check("tx_ready_last_stop", 32'(tx_ready), 32'd0);
            if (c == 177) check("tx_ready_after", 32'(tx_ready), 32'd1);
            if (c == 20) begin
                tx_data = 8'hFF;
                tx_valid = 1'b1;
            end
            if (c == 170) tx_valid = 1'b0;
        end
        tx_data = 8'h00;
        tick(4);
        check("tx_idle_line", 32'(TTYI), 32'd1);

        // RX 0xA5 held until consumed
        send_frame(8'hA5, 1, 1'b1, 0, 0);
        check("rx_a5_valid", 32'(rx_valid), 32'd1);
        check("rx_a5_data", 32'(rx_data), 32'hA5);
        tick(20);
        check("rx_a5_held", 32'(rx_valid), 32'd1);
        consume();
        check("rx_a5_cleared", 32'(rx_valid), 32'd0);

        // False start then 0x3C
        fe_base = fe_cnt;
        ttyo_drv = 1'b0;
        tick(5);
        ttyo_drv = 1'b1;
        tick(40);
        check("false_start_valid", 32'(rx_valid), 32'd0);
        check("false_start_fe", 32'(fe_cnt - fe_base), 32'd0);
        send_frame(8'h3C, 1, 1'b1, 0, 0);
        check("rx_3c_valid", 32'(rx_valid), 32'd1);
        check("rx_3c_data", 32'(rx_data), 32'h3C);
        consume();

        // Framing error followed by a long break
        fe_base = fe_cnt;
        send_frame(8'h41, 1, 1'b0, 0, 0);
        tick(400);
        ttyo_drv = 1'b1;
        tick(20);
        check("break_fe_once", 32'(fe_cnt - fe_base), 32'd1);
        check("break_no_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h42, 1, 1'b1, 0, 0);
        check("rx_42_valid", 32'(rx_valid), 32'd1);
        check("rx_42_data", 32'(rx_data), 32'h42);
        consume();

        // Overrun: second byte dropped
        ov_base = ov_cnt;
        send_frame(8'h11, 1, 1'b1, 0, 0);
        send_frame(8'h22, 1, 1'b1, 0, 0);
        tick(2);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_pulse_once", 32'(ov_cnt - ov_base), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        consume();

        // Delivery in the same cycle as rx_ready: replace without overrun
        ov_base = ov_cnt;
        send_frame(8'h11, 1, 1'b1, 0, 0);
        send_frame(8'h22, 1, 1'b1, 154, 155);
        tick(2);
        check("coinc_data_new", 32'(rx_data), 32'h22);
        check("coinc_valid", 32'(rx_valid), 32'd1);
        check("coinc_no_ovr", 32'(ov_cnt - ov_base), 32'd0);
        consume();
        check("coinc_cleared", 32'(rx_valid), 32'd0);

        // Reset mid-frame in loopback, then a clean 0x7F echo
        loop_en = 1'b1;
        fe_base = fe_cnt;
        tx_data = 8'h7F;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(134);
        check("pre_reset_bit7_low", 32'(TTYI), 32'd0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_ttyi", 32'(TTYI), 32'd1);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
        tick(200);
        check("post_rst_no_partial", 32'(rx_valid), 32'd0);
        check("post_rst_no_fe", 32'(fe_cnt - fe_base), 32'd0);
        tx_data = 8'h7F;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        waited = 0;
        while (!rx_valid && waited < 400) begin
            tick(1);
            waited++;
        end
        check("loop_7f_valid", 32'(rx_valid), 32'd1);
        check("loop_7f_data", 32'(rx_data), 32'h7F);
        waited = 0;
        while (!tx_ready && waited < 100) begin
            tick(1);
            waited++;
        end
        check("loop_tx_ready", 32'(tx_ready), 32'd1);
        check("loop_no_fe", 32'(fe_cnt - fe_base), 32'd0);
        consume();
        loop_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kim_tty_terminal.md
KIM_TTY_TERMINAL -- requirements
Module: kim_tty_terminal

Interface
REQ-001 Parameter CLKS_PER_BIT, default 3125, clk cycles per serial bit; legal values >= 4.
REQ-002 Parameter STOP_BITS, default 2, stop bits per transmitted frame; legal values 1 or 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte from host, to be sent to the KIM
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter can accept a byte
- TTYI  out  1  serial line into KIM TTY input; idle/mark = 1
- TTYO  in  1  serial line from KIM TTY output; idle/mark = 1; asynchronous
- rx_data  out  8  byte received from the KIM
- rx_valid  out  1  rx_data holds an unread byte
- rx_ready  in  1  host consumes rx_data
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- rx_overrun  out  1  one-cycle pulse: completed byte dropped

Function
REQ-004 Frame format SHALL be: start bit 0, 8 data bits LSB first, then stop bits at 1; no parity; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-005 The transmitter SHALL use the states IDLE, START, DATA and STOP; tx_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, when tx_valid && tx_ready: latch tx_data, enter START; TTYI = 0 from the next cycle (registered output).
REQ-007 In START, after CLKS_PER_BIT cycles, enter DATA with bit 0; in DATA, advance one bit every CLKS_PER_BIT cycles; after bit 7, enter STOP.
REQ-008 In STOP, TTYI = 1 for STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE; tx_ready = 1 on the cycle after the last stop cycle.
REQ-009 Frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles; back-to-back bytes SHALL have no extra idle cycles.
REQ-010 tx_data and tx_valid changes SHALL be ignored outside IDLE.
REQ-011 TTYO SHALL pass through a 2-flop synchronizer; all receive decisions use the synchronized value.
REQ-012 The receiver SHALL use the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 IDLE: a synchronized 1->0 transition enters START.
REQ-014 START: at CLKS_PER_BIT/2 (integer division) cycles after the edge, sample the line; if 1, treat it as a false start and return to IDLE; if 0, enter DATA.
REQ-015 DATA: sample each bit at CLKS_PER_BIT-cycle intervals from the start-bit mid-point; shift the bit in LSB first; after 8 bits, enter STOP.
REQ-016 STOP: sample once, one interval after bit 7.
- If 1: deliver the byte, return to IDLE.
- If 0: pulse rx_frame_err, discard the byte, enter WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until the synchronized line is 1, then enter IDLE; a break (continuous 0) SHALL produce exactly one rx_frame_err.
REQ-018 Delivery SHALL load rx_data and set rx_valid = 1 on the cycle after the stop sample.
- rx_valid stays 1 until a cycle with rx_ready = 1 clears it.
REQ-019 If a delivery occurs while rx_valid = 1 and rx_ready = 0: keep the old rx_data, drop the new byte, pulse rx_overrun for one cycle.
REQ-020 If a delivery coincides with rx_ready = 1: load the new byte, keep rx_valid = 1, no overrun.
REQ-021 The block SHALL NOT suppress the KIM's hardware echo: bits driven on TTYI and echoed on TTYO SHALL be received as normal bytes.
REQ-022 The transmitter and receiver SHALL operate independently and concurrently.

Reset
REQ-023 While reset = 1 (sampled at clk), outputs SHALL be: TTYI = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, rx_frame_err = 0, rx_overrun = 0; both state machines go to IDLE, counters clear, synchronizer flops = 1.
REQ-024 A reset during a frame SHALL abandon it: TTYI = 1 on the cycle after reset is sampled, and no partial byte is delivered.

Verification (CLKS_PER_BIT=16, STOP_BITS=2)
REQ-025 TX byte 0x55 accepted at cycle T -> TTYI = 0 for T+1..T+16; then 1,0,1,0,1,0,1,0 (16 cycles each); 1 for 32 cycles; tx_ready = 1 at T+177.
REQ-026 TTYO driven with a 0xA5 frame, 1 stop bit, rx_ready = 0 -> rx_valid = 1, rx_data = 0xA5, held until rx_ready pulses, then rx_valid = 0.
REQ-027 TTYO low for 5 cycles, then high -> no rx_valid and no rx_frame_err; the next valid 0x3C frame is received correctly.
REQ-028 TTYO frame 0x41 with stop bit 0, then line held low for 400 cycles -> exactly one rx_frame_err pulse, no rx_valid; a 0x42 frame after the line returns high is received.
REQ-029 Frames 0x11 then 0x22 with rx_ready = 0 -> rx_data = 0x11, one rx_overrun pulse; repeat with rx_ready = 1 on the second delivery cycle -> rx_data = 0x22, no overrun.
REQ-030 Reset asserted mid-DATA on TX and RX -> TTYI = 1 on the next cycle, tx_ready = 1, rx_valid = 0; a subsequent 0x7F transmits and receives correctly.
